// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the memory-access stage.
// Holds the bus widths, load/store op codes, state encodings and the
// small decode helpers used by both the stage and its lane unit.
package mem_access_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [ALU_OP_W-1:0]   alu_op_t;
  typedef logic [REG_W-1:0]      reg_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam alu_op_t EXE_LB_OP  = 8'b11100000;
  localparam alu_op_t EXE_LH_OP  = 8'b11100001;
  localparam alu_op_t EXE_LW_OP  = 8'b11100011;
  localparam alu_op_t EXE_LBU_OP = 8'b11100100;
  localparam alu_op_t EXE_LHU_OP = 8'b11100101;
  localparam alu_op_t EXE_SB_OP  = 8'b11101000;
  localparam alu_op_t EXE_SH_OP  = 8'b11101001;
  localparam alu_op_t EXE_SW_OP  = 8'b11101011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  function automatic logic is_mem_op(alu_op_t op);
    return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP,
                      EXE_LHU_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic is_store_op(alu_op_t op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic is_signed_load(alu_op_t op);
    return op inside {EXE_LB_OP, EXE_LH_OP};
  endfunction

  // Access size of a load/store; non-memory ops fall into word size
  function automatic size_t op_size(alu_op_t op);
    size_t sz;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sz = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sz = SZ_HALF;
      default:                          sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Low address bits forced to the natural alignment of the access
  function automatic logic [1:0] align_lo(alu_op_t op, logic [1:0] lo);
    logic [1:0] r;
    case (op_size(op))
      SZ_BYTE: r = lo;
      SZ_HALF: r = {lo[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // True when the low address bits break the natural alignment
  function automatic logic is_misaligned(alu_op_t op, logic [1:0] lo);
    logic r;
    case (op_size(op))
      SZ_HALF: r = lo[0];
      SZ_WORD: r = (lo != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// mem_lane: combinational byte-lane logic for the memory-access stage.
// Big-endian lanes: address offset 0 is bits 31:24. Produces the lane
// enables, the store data replicated across lanes and the extended load.
module mem_lane
  import mem_access_pkg::*;
(
  input  alu_op_t     aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;

  // Pick the addressed lane and build enables, store data and load result
  always_comb begin
    sel       = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    sext      = is_signed_load(aluop);
    half_v    = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    case (addr_lo)
      2'd0:    byte_v = rdata[31:24];
      2'd1:    byte_v = rdata[23:16];
      2'd2:    byte_v = rdata[15:8];
      default: byte_v = rdata[7:0];
    endcase
    case (op_size(aluop))
      SZ_BYTE: begin
        sel       = 4'b1000 >> addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sext & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{sext & half_v[15]}}, half_v};
      end
      default: begin
        sel       = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: pipeline stage between execute and write-back. Passes ALU
// results through in one cycle and runs a req/ack bus transaction for
// loads and stores, stalling upstream while the access is outstanding.
// Optional feature macro: MEM_ALIGN_CHECK_EN flags misaligned accesses
// instead of silently masking the low address bits.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  alu_op_t           aluop_i,
  input  reg_addr_t         wd_i,
  input  logic              wreg_i,
  input  reg_t              wdata_i,
  input  logic [31:0]       store_data_i,
  output logic              ready_o,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              valid_o,
  output reg_addr_t         wd_o,
  output logic              wreg_o,
  output reg_t              wdata_o,
  output logic              excp_o
);

  state_t     state;
  alu_op_t    op_q;
  reg_t       addr_q;
  logic [1:0] lo_q;
  reg_addr_t  wd_q;
  logic       wreg_q;

  logic [1:0]  lo_in;
  alu_op_t     lane_op;
  logic [1:0]  lane_lo;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign lo_in      = align_lo(aluop_i, wdata_i[1:0]);
  assign ready_o    = (state == ST_IDLE);
  assign stallreq_o = (state == ST_BUSY);
  assign mem_req_o  = (state == ST_BUSY);

  // The lane unit decodes the incoming op when idle and the latched op when busy
  assign lane_op = (state == ST_BUSY) ? op_q : aluop_i;
  assign lane_lo = (state == ST_BUSY) ? lo_q : lo_in;

  mem_lane u_lane (
    .aluop      (lane_op),
    .addr_lo    (lane_lo),
    .store_data (store_data_i),
    .rdata      (mem_rdata_i),
    .sel        (lane_sel),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign excp_o = 1'b0;
`endif

  // Stage FSM: accepts work when idle, holds the bus while busy, and drives
  // a one-cycle write-back pulse per accepted instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      lo_q        <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_sel_o   <= '0;
      mem_wdata_o <= '0;
      valid_o     <= 1'b0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      excp_o      <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      excp_o  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (!is_mem_op(aluop_i)) begin
              valid_o <= 1'b1;
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
              wdata_o <= wdata_i;
            end
`ifdef MEM_ALIGN_CHECK_EN
            else if (is_misaligned(aluop_i, wdata_i[1:0])) begin
              valid_o <= 1'b1;
              excp_o  <= 1'b1;
              wd_o    <= wd_i;
              wdata_o <= wdata_i;
            end
`endif
            else begin
              op_q        <= aluop_i;
              addr_q      <= wdata_i;
              lo_q        <= lo_in;
              wd_q        <= wd_i;
              wreg_q      <= wreg_i;
              mem_we_o    <= is_store_op(aluop_i);
              mem_addr_o  <= {wdata_i[ADDR_W-1:2], 2'b00};
              mem_sel_o   <= lane_sel;
              mem_wdata_o <= lane_wdata;
              state       <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            state       <= ST_IDLE;
            valid_o     <= 1'b1;
            wd_o        <= wd_q;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_sel_o   <= '0;
            mem_wdata_o <= '0;
            if (is_store_op(op_q)) begin
              wreg_o  <= 1'b0;
              wdata_o <= addr_q;
            end else begin
              wreg_o  <= wreg_q;
              wdata_o <= lane_load;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access with a write-back scoreboard.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  alu_op_t     aluop_i = '0;
  reg_addr_t   wd_i = '0;
  logic        wreg_i = 1'b0;
  reg_t        wdata_i = '0;
  logic [31:0] store_data_i = '0;
  logic        ready_o, stallreq_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        valid_o;
  reg_addr_t   wd_o;
  logic        wreg_o;
  reg_t        wdata_o;
  logic        excp_o;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        excp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   stall_cnt = 0;

  localparam alu_op_t ALU_OR = 8'b00100101;

  mem_access #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .aluop_i      (aluop_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .store_data_i (store_data_i),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_sel_o    (mem_sel_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .valid_o      (valid_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .excp_o       (excp_o)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one instruction on the execute-side inputs
  task automatic applyStimulus(input logic v, input alu_op_t op, input logic [4:0] wd,
                               input logic wr, input logic [31:0] wdat, input logic [31:0] sdat);
    valid_i      = v;
    aluop_i      = op;
    wd_i         = wd;
    wreg_i       = wr;
    wdata_i      = wdat;
    store_data_i = sdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},  32'(ready_o), 32'd1);
    checkOutput({tag, "_stall"},  32'(stallreq_o), 32'd0);
    checkOutput({tag, "_req"},    32'(mem_req_o), 32'd0);
    checkOutput({tag, "_we"},     32'(mem_we_o), 32'd0);
    checkOutput({tag, "_addr"},   mem_addr_o, 32'd0);
    checkOutput({tag, "_sel"},    32'(mem_sel_o), 32'd0);
    checkOutput({tag, "_mwdata"}, mem_wdata_o, 32'd0);
    checkOutput({tag, "_valid"},  32'(valid_o), 32'd0);
    checkOutput({tag, "_wd"},     32'(wd_o), 32'd0);
    checkOutput({tag, "_wreg"},   32'(wreg_o), 32'd0);
    checkOutput({tag, "_wdata"},  wdata_o, 32'd0);
    checkOutput({tag, "_excp"},   32'(excp_o), 32'd0);
  endtask

  // Load with k wait cycles; expected write-back value supplied by caller
  task automatic runLoad(input string tag, input alu_op_t op, input logic [31:0] addr,
                         input logic [31:0] rdata, input int k,
                         input logic [31:0] exp_addr, input logic [3:0] exp_sel,
                         input logic [31:0] exp_data);
    applyStimulus(1'b1, op, 5'd7, 1'b1, addr, 32'h0);
    sb.push_back('{wd: 5'd7, wreg: 1'b1, wdata: exp_data, excp: 1'b0});
    stall_cnt = 0;
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput({tag, "_req"},  32'(mem_req_o), 32'd1);
    checkOutput({tag, "_we"},   32'(mem_we_o), 32'd0);
    checkOutput({tag, "_addr"}, mem_addr_o, exp_addr);
    checkOutput({tag, "_sel"},  32'(mem_sel_o), 32'(exp_sel));
    for (int i = 0; i < k; i++) begin
      tick();
      checkOutput({tag, "_hold_stall"}, 32'(stallreq_o), 32'd1);
      checkOutput({tag, "_hold_sel"},   32'(mem_sel_o), 32'(exp_sel));
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = rdata;
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    checkOutput({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(k + 1));
    checkOutput({tag, "_stall_done"},   32'(stallreq_o), 32'd0);
  endtask

  // Count cycles with the stall request raised
  always @(negedge clk) begin
    if (stallreq_o) stall_cnt++;
  end

  // Write-back monitor: pop the scoreboard on each valid_o pulse
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("[TB] FAIL wb_unexpected observed=valid expected=none wdata=%h", wdata_o);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("wb_wd",    32'(wd_o), 32'(e.wd));
          checkOutput("wb_wreg",  32'(wreg_o), 32'(e.wreg));
          checkOutput("wb_wdata", wdata_o, e.wdata);
          checkOutput("wb_excp",  32'(excp_o), 32'(e.excp));
        end
      end else begin
        checkOutput("wb_idle_wreg", 32'(wreg_o), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values while rst is held low
    #12;
    checkResetValues("rst");
    tick();
    rst = 1'b1;
    tick();

    // Non-memory op passes straight through in one cycle
    applyStimulus(1'b1, ALU_OR, 5'd5, 1'b1, 32'h12345678, 32'h0);
    sb.push_back('{wd: 5'd5, wreg: 1'b1, wdata: 32'h12345678, excp: 1'b0});
    stall_cnt = 0;
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("alu_ready", 32'(ready_o), 32'd1);
    tick();
    checkOutput("alu_no_stall", 32'(stall_cnt), 32'd0);

    // Byte loads with three wait cycles, signed then unsigned
    runLoad("lb",  EXE_LB_OP,  32'h1001, 32'hAA80CCDD, 3, 32'h1000, 4'b0100, 32'hFFFFFF80);
    runLoad("lbu", EXE_LBU_OP, 32'h1001, 32'hAA80CCDD, 3, 32'h1000, 4'b0100, 32'h00000080);
    runLoad("lhu", EXE_LHU_OP, 32'h1000, 32'h8765CCDD, 0, 32'h1000, 4'b1100, 32'h00008765);
    runLoad("lh",  EXE_LH_OP,  32'h1002, 32'h1234F00D, 1, 32'h1000, 4'b0011, 32'hFFFFF00D);

    // Halfword store with zero-wait ack
    applyStimulus(1'b1, EXE_SH_OP, 5'd9, 1'b1, 32'h2002, 32'h0000BEEF);
    sb.push_back('{wd: 5'd9, wreg: 1'b0, wdata: 32'h2002, excp: 1'b0});
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("sh_we",     32'(mem_we_o), 32'd1);
    checkOutput("sh_sel",    32'(mem_sel_o), 32'b0011);
    checkOutput("sh_addr",   mem_addr_o, 32'h2000);
    checkOutput("sh_wdata",  mem_wdata_o, 32'hBEEFBEEF);
    checkOutput("sh_ready",  32'(ready_o), 32'd0);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("sh_req_done", 32'(mem_req_o), 32'd0);

    // Misaligned word load
`ifdef MEM_ALIGN_CHECK_EN
    applyStimulus(1'b1, EXE_LW_OP, 5'd11, 1'b1, 32'h3002, 32'h0);
    sb.push_back('{wd: 5'd11, wreg: 1'b0, wdata: 32'h3002, excp: 1'b1});
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("lw_mis_req",   32'(mem_req_o), 32'd0);
    checkOutput("lw_mis_stall", 32'(stallreq_o), 32'd0);
    tick();
`else
    runLoad("lw_mis", EXE_LW_OP, 32'h3002, 32'hCAFEF00D, 0, 32'h3000, 4'b1111, 32'hCAFEF00D);
`endif

    // Back-to-back: store acked zero-wait, ALU op held across the busy cycle
    applyStimulus(1'b1, EXE_SW_OP, 5'd3, 1'b1, 32'h4000, 32'h11223344);
    sb.push_back('{wd: 5'd3, wreg: 1'b0, wdata: 32'h4000, excp: 1'b0});
    tick();
    checkOutput("sw_sel",   32'(mem_sel_o), 32'b1111);
    checkOutput("sw_wdata", mem_wdata_o, 32'h11223344);
    applyStimulus(1'b1, ALU_OR, 5'd20, 1'b1, 32'hA5A5A5A5, 32'h0);
    checkOutput("b2b_busy_ready", 32'(ready_o), 32'd0);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    checkOutput("b2b_ready", 32'(ready_o), 32'd1);
    sb.push_back('{wd: 5'd20, wreg: 1'b1, wdata: 32'hA5A5A5A5, excp: 1'b0});
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tick();

    // Ack while idle must not start anything
    mem_ack_i = 1'b1;
    tick();
    tick();
    mem_ack_i = 1'b0;
    checkOutput("idle_ack_req", 32'(mem_req_o), 32'd0);

    // Asynchronous reset in the middle of a busy cycle
    applyStimulus(1'b1, EXE_LH_OP, 5'd12, 1'b1, 32'h5000, 32'h0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("abort_req_before", 32'(mem_req_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkResetValues("abort");
    mem_ack_i = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    tick();
    checkOutput("abort_valid", 32'(valid_o), 32'd0);
    tick();

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage that sits directly downstream of the execute stage. It registers the execute result, destination register and write-enable. For load/store ALU ops it runs a request/acknowledge transaction on the data bus, with byte-lane selection and load extension, and holds the pipeline through a stall request until the access completes. Its outputs feed the write-back stage.

## Interface
Parameters:
- `ADDR_W`, 32, data-bus address width; the low 2 bits select the byte lane.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: the execute stage presents an instruction this cycle.
- `aluop_i` in 8 (`AluOpBus`): operation code from execute.
- `wd_i` in 5 (`RegAddrBus`): destination register address.
- `wreg_i` in 1: destination write enable.
- `wdata_i` in 32 (`RegBus`): execute result; this is the effective address for load/store ops.
- `store_data_i` in 32: the rt value to store.
- `ready_o` out 1: the stage accepts `valid_i` this cycle.
- `stallreq_o` out 1: requests a freeze of the upstream stages.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: 1 = store.
- `mem_addr_o` out `ADDR_W`: word-aligned address (low 2 bits are 0).
- `mem_sel_o` out 4: byte-lane enables; bit 3 = bits 31:24.
- `mem_wdata_o` out 32: store data, with the byte/halfword replicated across lanes.
- `mem_ack_i` in 1: bus completion; read data is valid in the same cycle.
- `mem_rdata_i` in 32: bus read data.
- `valid_o` out 1: a result is presented to write-back.
- `wd_o` out 5, `wreg_o` out 1, `wdata_o` out 32: registered to write-back.
- `excp_o` out 1: misaligned-access flag for the presented result.

## Operation
- Byte order is big-endian. `addr[1:0]` = 0 selects bits 31:24.
- FSM states:
  - IDLE:
    - `ready_o`=1.
    - On `valid_i` with a non-memory op: register `wd/wreg/wdata` and set `valid_o`=1 next cycle.
    - On `valid_i` with a load/store op: latch the op, address, data and `wd`; go to BUSY.
  - BUSY:
    - `mem_req_o`=1, `ready_o`=0, `stallreq_o`=1.
    - All bus outputs are held stable until `mem_ack_i`.
    - On ack, go to IDLE and set `valid_o`=1 next cycle.
- Lane select:
  - Byte ops: one-hot on `addr[1:0]` (0→1000, 1→0100, 2→0010, 3→0001).
  - Halfword ops: `addr[1]`=0 → 1100, `addr[1]`=1 → 0011.
  - Word ops: 1111.
- Loads:
  - Extract the selected lane.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - `wdata_o` is captured from `mem_rdata_i` in the ack cycle.
- Stores:
  - `wreg_o` is forced to 0.
  - `wdata_o` = the address.
- `valid_o` is a one-cycle pulse per accepted instruction. When `valid_o`=0, `wreg_o`=0.
- An ack arriving in IDLE is ignored.
- `valid_i` with `ready_o`=0 is ignored. Upstream holds the instruction because `stallreq_o` is asserted.

## Timing
- Reset values: state=IDLE, `ready_o`=1, `stallreq_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_sel_o`=0, `mem_wdata_o`=0, `valid_o`=0, `wd_o`=0, `wreg_o`=0, `wdata_o`=0, `excp_o`=0.
- Latency:
  - Non-memory op: 1 cycle (`valid_i` at edge N → `valid_o` after edge N+1).
  - Memory op: 2 + k cycles, where k = the number of wait cycles before ack.
- Zero-wait bus: ack in the first BUSY cycle. The next accept can occur in the following cycle.
- `stallreq_o` is combinational from state and is high in every BUSY cycle.
- Reset during BUSY aborts immediately. `mem_req_o` drops asynchronously and a late ack is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Triggers: halfword ops with `addr[0]`=1, and word ops with `addr[1:0]`≠0.
  - Behaviour: skip BUSY, issue no bus request, and present `valid_o`=1, `excp_o`=1, `wreg_o`=0 after 1 cycle.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Misaligned low address bits are masked to the natural alignment.
  - `excp_o` is tied to 0.

## Structure
- Op codes go in the shared `defines.v`:
  - `EXE_LB_OP` 11100000, `EXE_LH_OP` 11100001, `EXE_LW_OP` 11100011, `EXE_LBU_OP` 11100100, `EXE_LHU_OP` 11100101.
  - `EXE_SB_OP` 11101000, `EXE_SH_OP` 11101001, `EXE_SW_OP` 11101011.
  - The shared file also holds the state encodings and `AluOpBus`/`RegBus`/`RegAddrBus`.
- One sub-module, `mem_lane`: combinational lane select, store replication and load extension.

## Test plan
- Reset with `rst`=0 → all outputs at reset values. Asynchronous check: assert `rst` mid-cycle and verify the outputs clear before the next edge.
- Non-memory op, `wd_i`=5, `wdata_i`=0x12345678 → next cycle `valid_o`=1, `wd_o`=5, `wreg_o`=1, `wdata_o`=0x12345678; `stallreq_o` never asserted.
- LB, addr=0x1001, rdata=0xAA80CCDD, ack after 3 wait cycles → `mem_sel_o`=0100, `stallreq_o` high for 4 cycles, `wdata_o`=0xFFFFFF80. The same case with LBU gives 0x00000080.
- SH, addr=0x2002, `store_data_i`=0x0000BEEF, zero-wait ack → `mem_we_o`=1, `mem_sel_o`=0011, `mem_addr_o`=0x2000, `mem_wdata_o`=0xBEEFBEEF, `wreg_o`=0.
- LW, addr=0x3002, with `MEM_ALIGN_CHECK_EN` → no `mem_req_o`, `excp_o`=1 after 1 cycle. Without the macro → `mem_addr_o`=0x3000, normal load.
- Back-to-back: an SW acked zero-wait, then an ALU op presented in the next cycle → accepted the cycle after ack, and both `valid_o` pulses appear in order.
